// File: rtl/channel_scheduler.sv
// ---------------------------------------------------------------------------
// channel_scheduler
//
// Time-multiplexing sequencer and voice allocator for the channel datapath.
// A free-running sweep presents every channel for two cycles: the update
// phase (pass=0), then the pass phase (pass=1). The block owns the per-channel
// note table, accepts one note-on/note-off request per sweep (in the sweep-end
// cycle), allocates voices with retrigger / free / oldest-released / steal
// priority, and ages released voices until they are reclaimed.
//
// Ports
//   clock, reset   : system clock; asynchronous active-high reset
//   req_valid      : request present
//   req_ready      : high only in the sweep-end cycle; accept = valid & ready
//   req_on         : 1 = note-on, 0 = note-off
//   req_note       : note number
//   req_velocity   : note-on velocity (ignored for note-off)
//   channel, pass  : channel index and phase currently presented
//   last           : high while channel == CHANNELS-1
//   note_state     : on flag of the presented channel
//   note_number    : note of the presented channel
//   velocity       : velocity of the presented channel
//   active         : per-channel valid bits
//   steal          : one-cycle pulse after a note-on evicted a sounding voice
// ---------------------------------------------------------------------------
module channel_scheduler #(
    parameter int CHANNELS = 8,
    parameter int CH_BITS  = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_on,
    input  logic [6:0]          req_note,
    input  logic [6:0]          req_velocity,
    output logic [CH_BITS-1:0]  channel,
    output logic                pass,
    output logic                last,
    output logic                note_state,
    output logic [6:0]          note_number,
    output logic [6:0]          velocity,
    output logic [CHANNELS-1:0] active,
    output logic                steal
);

    // Sweep position
    logic [CH_BITS-1:0]         r_channel;
    logic                       r_pass;

    // Note table
    logic [CHANNELS-1:0]        r_valid;
    logic [CHANNELS-1:0]        r_on;
    logic [CHANNELS-1:0][6:0]   r_note;
    logic [CHANNELS-1:0][6:0]   r_vel;
    logic [CHANNELS-1:0][7:0]   r_age;

    // Allocation and presentation state
    logic [CH_BITS-1:0]         r_rr;
    logic                       r_steal;
    logic                       r_note_state;
    logic [6:0]                 r_note_number;
    logic [6:0]                 r_velocity;

    logic                       w_last;
    logic                       w_sweep_end;
    logic                       w_accept;
    logic [CH_BITS-1:0]         w_ch_nxt;

    // Search results over the pre-edge table
    logic                       w_hit_found;
    logic [CH_BITS-1:0]         w_hit_idx;
    logic                       w_free_found;
    logic [CH_BITS-1:0]         w_free_idx;
    logic                       w_old_found;
    logic [CH_BITS-1:0]         w_old_idx;
    logic [7:0]                 w_old_age;
    logic                       w_off_found;
    logic [CH_BITS-1:0]         w_off_idx;

    // Write decision
    logic                       w_wr_en;
    logic [CH_BITS-1:0]         w_wr_idx;
    logic                       w_steal;

    // Next table state
    logic [CHANNELS-1:0]        w_valid_nxt;
    logic [CHANNELS-1:0]        w_on_nxt;
    logic [CHANNELS-1:0][6:0]   w_note_nxt;
    logic [CHANNELS-1:0][6:0]   w_vel_nxt;
    logic [CHANNELS-1:0][7:0]   w_age_nxt;

    assign w_last      = (r_channel == CH_BITS'(CHANNELS - 1));
    assign w_sweep_end = w_last && r_pass;
    assign w_accept    = req_valid && w_sweep_end;
    assign w_ch_nxt    = r_pass ? (r_channel + CH_BITS'(1)) : r_channel;

    // NOTE: every signal driven from an always_comb gets a default first, so
    // no path through the if/for structure can leave it unassigned (a latch).
    always_comb begin
        w_hit_found  = 1'b0;
        w_hit_idx    = '0;
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_old_found  = 1'b0;
        w_old_idx    = '0;
        w_old_age    = '0;
        w_off_found  = 1'b0;
        w_off_idx    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            // Retrigger candidate: any valid entry already holding this note
            if (!w_hit_found && r_valid[i] && (r_note[i] == req_note)) begin
                w_hit_found = 1'b1;
                w_hit_idx   = CH_BITS'(i);
            end
            if (!w_free_found && !r_valid[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = CH_BITS'(i);
            end
            // Oldest released voice; strict '>' keeps the lowest index on ties
            if (r_valid[i] && !r_on[i] && (!w_old_found || (r_age[i] > w_old_age))) begin
                w_old_found = 1'b1;
                w_old_idx   = CH_BITS'(i);
                w_old_age   = r_age[i];
            end
            if (!w_off_found && r_valid[i] && r_on[i] && (r_note[i] == req_note)) begin
                w_off_found = 1'b1;
                w_off_idx   = CH_BITS'(i);
            end
        end
    end

    always_comb begin
        w_wr_en  = 1'b0;
        w_wr_idx = '0;
        w_steal  = 1'b0;
        if (w_accept) begin
            if (req_on) begin
                w_wr_en = 1'b1;
                if (w_hit_found) begin
                    w_wr_idx = w_hit_idx;
                end else if (w_free_found) begin
                    w_wr_idx = w_free_idx;
                end else if (w_old_found) begin
                    w_wr_idx = w_old_idx;
                end else begin
                    w_wr_idx = r_rr;
                    w_steal  = 1'b1;
                end
            end else if (w_off_found) begin
                w_wr_en  = 1'b1;
                w_wr_idx = w_off_idx;
            end
        end
    end

    // Age update first, then the request write overlays it so the request
    // wins when both touch the same entry.
    always_comb begin
        w_valid_nxt = r_valid;
        w_on_nxt    = r_on;
        w_note_nxt  = r_note;
        w_vel_nxt   = r_vel;
        w_age_nxt   = r_age;
        if (w_sweep_end) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (r_valid[i] && !r_on[i]) begin
                    if (r_age[i] != 8'hFF) begin
                        w_age_nxt[i] = r_age[i] + 8'd1;
                    end
                    if (w_age_nxt[i] == 8'hFF) begin
                        w_valid_nxt[i] = 1'b0;
                    end
                end
            end
        end
        if (w_wr_en) begin
            w_on_nxt[w_wr_idx]  = req_on;
            w_age_nxt[w_wr_idx] = '0;
            if (req_on) begin
                w_valid_nxt[w_wr_idx] = 1'b1;
                w_note_nxt[w_wr_idx]  = req_note;
                w_vel_nxt[w_wr_idx]   = req_velocity;
            end
        end
    end

    // NOTE: the note table is reset along with the control state because a
    // reset must leave no voice allocated; it is small enough to live in flops.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_channel     <= '0;
            r_pass        <= 1'b0;
            r_valid       <= '0;
            r_on          <= '0;
            r_note        <= '0;
            r_vel         <= '0;
            r_age         <= '0;
            r_rr          <= '0;
            r_steal       <= 1'b0;
            r_note_state  <= 1'b0;
            r_note_number <= '0;
            r_velocity    <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values regardless of statement order.
            r_channel     <= w_ch_nxt;
            r_pass        <= ~r_pass;
            r_valid       <= w_valid_nxt;
            r_on          <= w_on_nxt;
            r_note        <= w_note_nxt;
            r_vel         <= w_vel_nxt;
            r_age         <= w_age_nxt;
            r_rr          <= w_steal ? (r_rr + CH_BITS'(1)) : r_rr;
            r_steal       <= w_steal;
            // Present the post-write entry so a fresh write shows up on the
            // very next channel 0.
            r_note_state  <= w_on_nxt[w_ch_nxt];
            r_note_number <= w_note_nxt[w_ch_nxt];
            r_velocity    <= w_vel_nxt[w_ch_nxt];
        end
    end

    assign channel     = r_channel;
    assign pass        = r_pass;
    assign last        = w_last;
    assign req_ready   = w_sweep_end;
    assign note_state  = r_note_state;
    assign note_number = r_note_number;
    assign velocity    = r_velocity;
    assign active      = r_valid;
    assign steal       = r_steal;

endmodule

// File: tb/tb_channel_scheduler.sv
// ---------------------------------------------------------------------------
// tb_channel_scheduler
//
// Self-checking bench: directed scenarios plus randomized requests, all
// compared every cycle against a behavioural model of the sweep (derived from
// a cycle count) and of the note table (an array of entries with the
// allocation rules applied by plain searches).
// ---------------------------------------------------------------------------
module tb_channel_scheduler;

    localparam int CH = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_on = 1'b0;
    logic [6:0]    req_note = '0;
    logic [6:0]    req_velocity = '0;
    logic [2:0]    channel;
    logic          pass;
    logic          last;
    logic          note_state;
    logic [6:0]    note_number;
    logic [6:0]    velocity;
    logic [CH-1:0] active;
    logic          steal;

    channel_scheduler #(.CHANNELS(CH), .CH_BITS(3)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_on       (req_on),
        .req_note     (req_note),
        .req_velocity (req_velocity),
        .channel      (channel),
        .pass         (pass),
        .last         (last),
        .note_state   (note_state),
        .note_number  (note_number),
        .velocity     (velocity),
        .active       (active),
        .steal        (steal)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    typedef struct {
        bit valid;
        bit on;
        int note;
        int vel;
        int age;
    } entry_t;

    entry_t tbl [CH];
    int     t;            // cycles since reset release
    int     rr;
    bit     exp_steal;
    bit     accepted;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
        else n_pass++;
    endtask

    task automatic model_clear();
        for (int i = 0; i < CH; i++) tbl[i] = '{valid: 0, on: 0, note: 0, vel: 0, age: 0};
        t = 0;
        rr = 0;
        exp_steal = 0;
        accepted = 0;
    endtask

    // Entry chosen by a request against the current (pre-edge) table, -1 = none.
    task automatic model_target(output int idx, output bit stole);
        int best;
        idx = -1;
        stole = 0;
        if (req_on) begin
            for (int i = 0; i < CH; i++)
                if (idx < 0 && tbl[i].valid && tbl[i].note == int'(req_note)) idx = i;
            for (int i = 0; i < CH; i++)
                if (idx < 0 && !tbl[i].valid) idx = i;
            if (idx < 0) begin
                best = -1;
                for (int i = 0; i < CH; i++)
                    if (tbl[i].valid && !tbl[i].on && tbl[i].age > best) begin
                        best = tbl[i].age;
                        idx = i;
                    end
            end
            if (idx < 0) begin
                idx = rr;
                stole = 1;
            end
        end else begin
            for (int i = 0; i < CH; i++)
                if (idx < 0 && tbl[i].valid && tbl[i].on && tbl[i].note == int'(req_note)) idx = i;
        end
    endtask

    task automatic model_edge();
        int idx;
        bit stole;
        exp_steal = 0;
        accepted  = 0;
        if ((t % (2 * CH)) == 2 * CH - 1) begin
            idx = -1;
            stole = 0;
            if (req_valid) begin
                model_target(idx, stole);
                accepted = 1;
            end
            for (int i = 0; i < CH; i++)
                if (tbl[i].valid && !tbl[i].on) begin
                    if (tbl[i].age < 255) tbl[i].age++;
                    if (tbl[i].age == 255) tbl[i].valid = 0;
                end
            if (idx >= 0) begin
                tbl[idx].on  = req_on;
                tbl[idx].age = 0;
                if (req_on) begin
                    tbl[idx].valid = 1;
                    tbl[idx].note  = int'(req_note);
                    tbl[idx].vel   = int'(req_velocity);
                end
            end
            if (stole) begin
                rr = (rr + 1) % CH;
                exp_steal = 1;
            end
        end
        t++;
    endtask

    task automatic compare_all();
        int ch;
        logic [CH-1:0] a;
        ch = (t / 2) % CH;
        for (int i = 0; i < CH; i++) a[i] = tbl[i].valid;
        check("channel",     32'(channel),     ch);
        check("pass",        32'(pass),        t % 2);
        check("last",        32'(last),        32'(ch == CH - 1));
        check("req_ready",   32'(req_ready),   32'((t % (2 * CH)) == 2 * CH - 1));
        check("note_state",  32'(note_state),  32'(tbl[ch].on));
        check("note_number", 32'(note_number), tbl[ch].note);
        check("velocity",    32'(velocity),    tbl[ch].vel);
        check("active",      32'(active),      32'(a));
        check("steal",       32'(steal),       32'(exp_steal));
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic tick();
        @(posedge clock);
        if (reset) model_clear();
        else model_edge();
        @(negedge clock);
        compare_all();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    // Called on a falling edge; asserts reset mid-cycle and checks it bites
    // immediately, without waiting for a clock edge.
    task automatic apply_reset(input int n);
        reset = 1'b1;
        #1;
        model_clear();
        check("rst_channel", 32'(channel), 0);
        check("rst_active",  32'(active),  0);
        check("rst_note",    32'(note_number), 0);
        compare_all();
        @(negedge clock);
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic send(input bit on, input int note, input int vel);
        bit got;
        req_valid    = 1'b1;
        req_on       = on;
        req_note     = 7'(note);
        req_velocity = 7'(vel);
        got = 0;
        for (int k = 0; k < 4 * CH && !got; k++) begin
            tick();
            got = accepted;
        end
        check("accept_timeout", 32'(got), 1);
        req_valid = 1'b0;
    endtask

    task automatic expect_ch(input string tag, input int ch, input bit st, input int note, input int vel);
        int k;
        k = 0;
        while (((t / 2) % CH) != ch && k < 4 * CH) begin
            tick();
            k++;
        end
        check({tag, "_ch"},    32'(channel),     ch);
        check({tag, "_state"}, 32'(note_state),  32'(st));
        check({tag, "_note"},  32'(note_number), note);
        check({tag, "_vel"},   32'(velocity),    vel);
    endtask

    initial begin
        int n;
        model_clear();
        #2;
        reset = 1'b1;
        @(negedge clock);

        // Reset and sweep
        apply_reset(3);
        n = 0;
        repeat (4 * CH) begin
            tick();
            if (req_ready) n++;
        end
        check("ready_pulses", 32'(n), 2);

        // Allocation order
        send(1, 60, 100);
        send(1, 64, 100);
        send(1, 67, 100);
        check("alloc_active", 32'(active), 32'(8'b0000_0111));
        expect_ch("alloc_ch1", 1, 1, 64, 100);

        // Note-off and aging
        send(0, 64, 0);
        expect_ch("off_ch1", 1, 0, 64, 100);
        while ((t % (2 * CH)) != 0) tick();
        // Age already advanced once if the sweep end passed during expect_ch
        run(253 * 2 * CH);
        check("age_hold", 32'(active[1]), 1);
        run(2 * 2 * CH);
        check("age_expire", 32'(active[1]), 0);
        send(0, 50, 0);
        check("off_absent", 32'(active), 32'(8'b0000_0101));

        // Retrigger and reuse
        apply_reset(2);
        send(1, 60, 100);
        send(1, 64, 100);
        send(1, 67, 100);
        send(0, 60, 0);
        send(1, 60, 20);
        expect_ch("retrig_ch0", 0, 1, 60, 20);
        send(1, 72, 90);
        expect_ch("reuse_ch3", 3, 1, 72, 90);
        check("reuse_active", 32'(active), 32'(8'b0000_1111));

        // Stealing
        apply_reset(2);
        for (int i = 0; i < CH; i++) send(1, 40 + i, 50);
        check("full_active", 32'(active), 32'hFF);
        send(1, 80, 30);
        check("steal_pulse", 32'(steal), 1);
        tick();
        check("steal_drop", 32'(steal), 0);
        expect_ch("steal_ch0", 0, 1, 80, 30);
        send(1, 81, 31);
        check("steal2_pulse", 32'(steal), 1);
        expect_ch("steal_ch1", 1, 1, 81, 31);

        // Async reset mid-request
        while (((t / 2) % CH) != 3) tick();
        req_valid    = 1'b1;
        req_on       = 1'b1;
        req_note     = 7'd90;
        req_velocity = 7'd11;
        apply_reset(3);
        n = 0;
        while (!req_ready && n < 4 * CH) begin
            tick();
            n++;
        end
        check("ready_after_rst", 32'(n), 15);
        tick();
        check("rst_req_accepted", 32'(accepted), 1);
        req_valid = 1'b0;
        expect_ch("rst_req_ch0", 0, 1, 90, 11);
        check("rst_req_active", 32'(active), 32'(8'b0000_0001));

        // Randomized traffic against the model
        for (int r = 0; r < 300; r++) begin
            run($urandom_range(0, 20));
            send($urandom_range(0, 2) != 0, 60 + $urandom_range(0, 11), $urandom_range(1, 127));
        end
        run(2 * CH);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
